axi_sram_slave: RTL and testbench
=================================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter ADDR_W, default 16, SRAM word-address width (SRAM depth 2^ADDR_W words of 32 bits).
REQ-002 aclk  in  1  single clock; all logic on rising edge.
REQ-003 aresetn  in  1  reset; asynchronous assert, active-low.
REQ-004 AR channel: arid in 4, araddr in 32, arlen in 8, arsize in 3, arburst in 2, arlock in 2, arcache in 4, arprot in 3, arvalid in 1, arready out 1.
REQ-005 R channel: rid out 4, rdata out 32, rresp out 2, rlast out 1, rvalid out 1, rready in 1.
REQ-006 AW channel: awid in 4, awaddr in 32, awlen in 4, awsize in 3, awburst in 2, awlock in 2, awcache in 4, awprot in 3, awvalid in 1, awready out 1.
REQ-007 W channel: wid in 4, wdata in 32, wstrb in 4, wlast in 1, wvalid in 1, wready out 1; B channel: bid out 4, bresp out 2, bvalid out 1, bready in 1.
REQ-008 SRAM port: ram_en out 1, ram_wen out 4 (byte write enables), ram_addr out ADDR_W, ram_wdata out 32, ram_rdata in 32 (valid the cycle after ram_en with ram_wen=0).

Function
REQ-009 FSM states SHALL be IDLE, RD_ADDR, RD_WAIT, RD_DATA, WR_DATA, WR_RESP; one transaction outstanding at a time.
REQ-010 In IDLE arready/awready SHALL be high only for the granted channel; never both in the same cycle.
REQ-011 Arbitration: one valid -> grant it; both valid -> grant channel not granted last; last-grant reset value = write (first contention goes to read).
REQ-012 Handshake captures id, word address addr[ADDR_W+1:2], beat count len[3:0]+1 (arlen[7:4], size, burst, lock, cache, prot ignored; all bursts treated as INCR, 4 bytes/beat).
REQ-013 Read: AR handshake in cycle T -> RD_ADDR at T+1 (ram_en=1, ram_wen=0) -> RD_WAIT at T+2 -> rdata register loads ram_rdata, RD_DATA at T+3 with rvalid=1.
REQ-014 rvalid, rdata, rid, rlast SHALL hold stable until rready; rlast=1 only on final beat; rresp=2'b00.
REQ-015 R handshake on non-final beat -> word address +1, RD_ADDR next cycle; on final beat -> IDLE.
REQ-016 Write: AW handshake in cycle T -> WR_DATA at T+1 with wready=1.
REQ-017 Each W handshake SHALL drive ram_en=1, ram_wen=wstrb, ram_wdata=wdata, ram_addr=current word address in that same cycle, then increment address.
REQ-018 Burst end is set by beat counter, not wlast; after final beat -> WR_RESP, bvalid=1, bid=captured awid, held until bready, then IDLE.
REQ-019 bresp SHALL be 2'b10 (SLVERR) if wlast mismatched the counter on any beat of the burst, else 2'b00; data is written regardless.
REQ-020 Word address SHALL wrap modulo 2^ADDR_W; upper araddr/awaddr bits alias.
REQ-021 ram_en SHALL be 0 outside RD_ADDR and W handshakes; wstrb=0 beat still asserts ram_en with ram_wen=0 (no modification).

Reset
REQ-022 On aresetn low: state IDLE, arready, awready, wready, rvalid, bvalid, rlast, ram_en = 0; ram_wen=0; rdata, rid, bid, rresp, bresp, ram_addr, ram_wdata = 0.
REQ-023 Reset mid-transaction SHALL drop it silently: no further SRAM write, no R/B response after release.

Structure
REQ-024 Shared package axi_pkg SHALL hold state enum, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, BURST_INCR=2'b01.
REQ-025 Single flat module; no sub-module; SRAM instantiated outside.

Verification
REQ-026 Single read: araddr=0x10, arlen=0, SRAM[4]=0xDEADBEEF, rready=1 -> rvalid at T+3, rdata=0xDEADBEEF, rlast=1, rresp=0.
REQ-027 Write burst: awaddr=0x20, awlen=3, wdata 1..4, wstrb=4'hF, wlast on beat 4 -> SRAM[8..11]=1..4, bvalid once, bresp=0.
REQ-028 Byte strobe: SRAM[0]=0x11223344, write 0xAABBCCDD wstrb=4'b0101 -> SRAM[0]=0x11BB33DD.
REQ-029 Contention: arvalid and awvalid both high from reset -> read granted first, write next; rready held 0 for 5 cycles -> rdata/rlast stable.
REQ-030 Wrap/error/reset: ADDR_W=4, awaddr=0x3C, awlen=1, wlast on beat 1 -> SRAM[15], SRAM[0] written, bresp=2'b10; aresetn low during WR_DATA -> no writes, no bvalid.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the SRAM slave: FSM state encoding and the
// response/burst codes used on the AXI channels.
package axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_WAIT,
    RD_DATA,
    WR_DATA,
    WR_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

endpackage

// File: rtl/axi_sram_slave.sv
// AXI3 slave bridging one outstanding read or write burst at a time onto a
// single-port synchronous SRAM (one-cycle read latency, byte write enables).
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  // AR channel
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  // R channel
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  // AW channel
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [3:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  // W channel
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  // B channel
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  // SRAM port
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_t              state, next_state;
  logic                run;          // low until the first edge after reset release
  logic                last_wr;      // last granted channel was write
  logic [ADDR_W-1:0]   addr_q;
  logic [4:0]          beats_left;
  logic                err_q;
  logic                grant_rd, grant_wr;
  logic                ar_hs, aw_hs, r_hs, w_hs;
  logic                final_beat, wlast_bad;

  // Burst type, size, lock, cache, prot, wid and the sub-word/aliased
  // address bits play no part in this slave.
  logic unused_ok;
  assign unused_ok = ^{arlen[7:4], arsize, arburst, arlock, arcache, arprot,
                       awsize, awburst, awlock, awcache, awprot, wid,
                       araddr[31:ADDR_W+2], araddr[1:0],
                       awaddr[31:ADDR_W+2], awaddr[1:0]};

  // Fair alternation under contention; a lone request is always granted.
  assign grant_rd = arvalid && (!awvalid || last_wr);
  assign grant_wr = awvalid && (!arvalid || !last_wr);

  assign ar_hs      = arready && arvalid;
  assign aw_hs      = awready && awvalid;
  assign r_hs       = rvalid && rready;
  assign w_hs       = wready && wvalid;
  assign final_beat = (beats_left == 5'd1);
  assign wlast_bad  = (wlast != final_beat);

  assign ram_addr = addr_q;
  assign rresp    = RESP_OKAY;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: every output is defaulted before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    next_state = state;
    arready    = 1'b0;
    awready    = 1'b0;
    wready     = 1'b0;
    rvalid     = 1'b0;
    bvalid     = 1'b0;
    ram_en     = 1'b0;
    ram_wen    = 4'h0;
    ram_wdata  = 32'h0;
    case (state)
      IDLE: begin
        if (run && grant_rd) begin
          arready    = 1'b1;
          next_state = RD_ADDR;
        end else if (run && grant_wr) begin
          awready    = 1'b1;
          next_state = WR_DATA;
        end
      end
      RD_ADDR: begin
        ram_en     = 1'b1;
        next_state = RD_WAIT;
      end
      RD_WAIT: next_state = RD_DATA;
      RD_DATA: begin
        rvalid = 1'b1;
        if (rready) next_state = rlast ? IDLE : RD_ADDR;
      end
      WR_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          ram_en    = 1'b1;
          ram_wen   = wstrb;
          ram_wdata = wdata;
          if (final_beat) next_state = WR_RESP;
        end
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (bready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run        <= 1'b0;
      last_wr    <= 1'b1;
      addr_q     <= '0;
      beats_left <= 5'd0;
      err_q      <= 1'b0;
      rid        <= 4'h0;
      bid        <= 4'h0;
      rdata      <= 32'h0;
      rlast      <= 1'b0;
      bresp      <= RESP_OKAY;
    end else begin
      run <= 1'b1;
      if (ar_hs) begin
        rid        <= arid;
        addr_q     <= araddr[ADDR_W+1:2];
        beats_left <= {1'b0, arlen[3:0]} + 5'd1;
        last_wr    <= 1'b0;
      end
      if (aw_hs) begin
        bid        <= awid;
        addr_q     <= awaddr[ADDR_W+1:2];
        beats_left <= {1'b0, awlen} + 5'd1;
        err_q      <= 1'b0;
        last_wr    <= 1'b1;
      end
      if (state == RD_WAIT) begin
        rdata <= ram_rdata;
        rlast <= final_beat;
      end
      if (r_hs) begin
        rlast <= 1'b0;
        if (!rlast) begin
          addr_q     <= addr_q + 1'b1;
          beats_left <= beats_left - 5'd1;
        end
      end
      if (w_hs) begin
        addr_q     <= addr_q + 1'b1;
        beats_left <= beats_left - 5'd1;
        err_q      <= err_q | wlast_bad;
        // Response is fixed on the final beat and held through WR_RESP.
        if (final_beat) bresp <= (err_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a 16-word behavioural SRAM:
// table of single-beat write/read-back vectors plus hand-written sequences.
module tb_axi_sram_slave;

  localparam int AW = 4;

  logic aclk, aresetn;
  logic [3:0]  arid;   logic [31:0] araddr; logic [7:0] arlen;
  logic [2:0]  arsize; logic [1:0]  arburst; logic [1:0] arlock;
  logic [3:0]  arcache; logic [2:0] arprot; logic arvalid, arready;
  logic [3:0]  rid;    logic [31:0] rdata;  logic [1:0] rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid;   logic [31:0] awaddr; logic [3:0] awlen;
  logic [2:0]  awsize; logic [1:0]  awburst; logic [1:0] awlock;
  logic [3:0]  awcache; logic [2:0] awprot; logic awvalid, awready;
  logic [3:0]  wid;    logic [31:0] wdata;  logic [3:0] wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;    logic [1:0]  bresp;  logic bvalid, bready;
  logic        ram_en; logic [3:0]  ram_wen; logic [AW-1:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  logic [31:0] mem [16];
  logic [31:0] exp_rd [16];
  int checks = 0;
  int errors = 0;

  axi_sram_slave #(.ADDR_W(AW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Synchronous SRAM: byte-enabled write, registered read.
  always @(posedge aclk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_wen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct {
    string       name;
    logic [31:0] addr;
    int          idx;
    logic [31:0] preload;
    logic [31:0] wdat;
    logic [3:0]  strb;
    logic [31:0] expect_word;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return awready;
      1: return wready;
      2: return bvalid;
      3: return arready;
      default: return rvalid;
    endcase
  endfunction

  task automatic wait_for(input int which, input string name);
    int n = 0;
    while (!sig(which) && n < 20) begin
      @(posedge aclk); #1;
      n++;
    end
    if (!sig(which)) check({name, " timeout"}, 32'd0, 32'd1);
  endtask

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] len, input logic [31:0] base,
                    input logic [3:0] strb, input logic [3:0] id, input int wlast_beat,
                    input logic [1:0] exp_resp);
    awvalid = 1'b1; awaddr = addr; awlen = len; awid = id;
    #1;
    wait_for(0, "awready");
    tick();
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = base + i; wstrb = strb; wlast = (i == wlast_beat);
      #1;
      wait_for(1, "wready");
      check("w ram_en", {31'd0, ram_en}, 32'd1);
      check("w ram_wen", {28'd0, ram_wen}, {28'd0, strb});
      check("w ram_addr", {28'd0, ram_addr}, ((addr >> 2) + i) & 32'hF);
      check("w ram_wdata", ram_wdata, base + i);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    #1;
    wait_for(2, "bvalid");
    check("bresp", {30'd0, bresp}, {30'd0, exp_resp});
    check("bid", {28'd0, bid}, {28'd0, id});
    tick();
    bready = 1'b0;
    check("bvalid once", {31'd0, bvalid}, 32'd0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id);
    arvalid = 1'b1; araddr = addr; arlen = {4'h0, len}; arid = id;
    #1;
    wait_for(3, "arready");
    tick();
    arvalid = 1'b0;
    rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      wait_for(4, "rvalid");
      check("rdata", rdata, exp_rd[i]);
      check("rlast", {31'd0, rlast}, {31'd0, (i == int'(len))});
      check("rid", {28'd0, rid}, {28'd0, id});
      check("rresp", {30'd0, rresp}, 32'd0);
      tick();
    end
    rready = 1'b0;
    check("rvalid after burst", {31'd0, rvalid}, 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    vecs[0] = '{"strobe 0101", 32'h0000_0000, 0, 32'h1122_3344, 32'hAABB_CCDD, 4'b0101, 32'h11BB_33DD};
    vecs[1] = '{"strobe none", 32'h0000_0004, 1, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0000, 32'hFFFF_FFFF};
    vecs[2] = '{"strobe 1000", 32'h0000_0008, 2, 32'h0000_0000, 32'h1234_5678, 4'b1000, 32'h1200_0000};
    vecs[3] = '{"alias 0x4C", 32'h0000_004C, 3, 32'h0000_0000, 32'hA5A5_A5A5, 4'b1111, 32'hA5A5_A5A5};
    vecs[4] = '{"alias high", 32'hFFFF_0018, 6, 32'h8765_4321, 32'hDEAD_BEEF, 4'b0011, 32'h8765_BEEF};

    for (int i = 0; i < 16; i++) begin mem[i] = 32'h0; exp_rd[i] = 32'h0; end
    mem[4] = 32'hCAFE_F00D;
    ram_rdata = 32'h0;
    arsize = 3'd2; arburst = 2'b01; arlock = 2'b00; arcache = 4'h0; arprot = 3'h0;
    awsize = 3'd2; awburst = 2'b01; awlock = 2'b00; awcache = 4'h0; awprot = 3'h0;
    wid = 4'h0; wdata = 32'h0; wstrb = 4'h0; wlast = 1'b0; wvalid = 1'b0;
    rready = 1'b0; bready = 1'b0;

    // Contention from reset: both requests pending throughout reset.
    arvalid = 1'b1; araddr = 32'h10; arlen = 8'h0; arid = 4'h5;
    awvalid = 1'b1; awaddr = 32'h0;  awlen = 4'h0; awid = 4'h3;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst arready", {31'd0, arready}, 32'd0);
    check("rst awready", {31'd0, awready}, 32'd0);
    check("rst rvalid",  {31'd0, rvalid},  32'd0);
    check("rst bvalid",  {31'd0, bvalid},  32'd0);
    check("rst ram_en",  {31'd0, ram_en},  32'd0);
    check("rst rlast",   {31'd0, rlast},   32'd0);
    check("rst rdata",   rdata, 32'd0);
    aresetn = 1'b1;
    tick();
    check("cont arready first", {31'd0, arready}, 32'd1);
    check("cont awready first", {31'd0, awready}, 32'd0);
    tick(); tick(); tick();
    check("cont rvalid", {31'd0, rvalid}, 32'd1);
    check("cont rdata", rdata, 32'hCAFE_F00D);
    held = rdata;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("cont hold rvalid", {31'd0, rvalid}, 32'd1);
      check("cont hold rdata", rdata, held);
      check("cont hold rlast", {31'd0, rlast}, 32'd1);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("cont awready next", {31'd0, awready}, 32'd1);
    check("cont arready next", {31'd0, arready}, 32'd0);
    arvalid = 1'b0;
    tick();
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'h77; wstrb = 4'hF; wlast = 1'b1;
    #1;
    check("cont wready", {31'd0, wready}, 32'd1);
    tick();
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    #1;
    check("cont bvalid", {31'd0, bvalid}, 32'd1);
    check("cont bid", {28'd0, bid}, 32'd3);
    check("cont bresp", {30'd0, bresp}, 32'd0);
    tick();
    bready = 1'b0;
    check("cont mem0", mem[0], 32'h77);

    // Single read latency: handshake at T, rvalid at T+3.
    mem[4] = 32'hDEAD_BEEF;
    arvalid = 1'b1; araddr = 32'h10; arlen = 8'h0; arid = 4'h2; rready = 1'b1;
    #1;
    wait_for(3, "lat arready");
    tick();
    arvalid = 1'b0;
    check("lat T+1 ram_en", {31'd0, ram_en}, 32'd1);
    check("lat T+1 ram_wen", {28'd0, ram_wen}, 32'd0);
    check("lat T+1 ram_addr", {28'd0, ram_addr}, 32'd4);
    tick();
    check("lat T+2 rvalid", {31'd0, rvalid}, 32'd0);
    check("lat T+2 ram_en", {31'd0, ram_en}, 32'd0);
    tick();
    check("lat T+3 rvalid", {31'd0, rvalid}, 32'd1);
    check("lat rdata", rdata, 32'hDEAD_BEEF);
    check("lat rlast", {31'd0, rlast}, 32'd1);
    check("lat rid", {28'd0, rid}, 32'd2);
    tick();
    rready = 1'b0;
    check("lat rvalid drop", {31'd0, rvalid}, 32'd0);

    // Four-beat burst write and read-back.
    wr(32'h20, 4'd3, 32'd1, 4'hF, 4'h9, 3, 2'b00);
    for (int i = 0; i < 4; i++) check("burst mem", mem[8 + i], 32'd1 + i);
    for (int i = 0; i < 4; i++) exp_rd[i] = 32'd1 + i;
    rd(32'h20, 4'd3, 4'hA);

    // Table of single-beat write / read-back vectors.
    for (int v = 0; v < 5; v++) begin
      mem[vecs[v].idx] = vecs[v].preload;
      wr(vecs[v].addr, 4'd0, vecs[v].wdat, vecs[v].strb, 4'(v), 0, 2'b00);
      check({vecs[v].name, " mem"}, mem[vecs[v].idx], vecs[v].expect_word);
      exp_rd[0] = vecs[v].expect_word;
      rd(vecs[v].addr, 4'd0, 4'(v + 1));
    end

    // Address wrap with wlast on the wrong beat.
    wr(32'h3C, 4'd1, 32'h55, 4'hF, 4'h6, 0, 2'b10);
    check("wrap mem15", mem[15], 32'h55);
    check("wrap mem0", mem[0], 32'h56);

    // Reset asserted while in WR_DATA drops the burst.
    mem[5] = 32'h5A5A_5A5A; mem[6] = 32'hA5A5_5A5A;
    awvalid = 1'b1; awaddr = 32'h14; awlen = 4'd1; awid = 4'hC;
    #1;
    wait_for(0, "rstw awready");
    tick();
    awvalid = 1'b0;
    check("rstw wready", {31'd0, wready}, 32'd1);
    wvalid = 1'b1; wdata = 32'h99; wstrb = 4'hF; wlast = 1'b0;
    aresetn = 1'b0;
    #1;
    check("rstw ram_en", {31'd0, ram_en}, 32'd0);
    check("rstw wready low", {31'd0, wready}, 32'd0);
    tick(); tick();
    wvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rstw bvalid", {31'd0, bvalid}, 32'd0);
      check("rstw rvalid", {31'd0, rvalid}, 32'd0);
      check("rstw ram_en", {31'd0, ram_en}, 32'd0);
    end
    check("rstw mem5", mem[5], 32'h5A5A_5A5A);
    check("rstw mem6", mem[6], 32'hA5A5_5A5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
